// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// mul_arb_pkg : shared constants for the multiplier-sharing arbiter
// Rev 1.0
// ============================================================================
package mul_arb_pkg;

   localparam int DEF_NREQ    = 4;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_TIMEOUT = 255;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   function automatic int idxw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_rr_pick.sv
`default_nettype none
// ============================================================================
// mul_rr_pick : rotate-priority encoder, first set request at or after ptr
// Rev 1.0
// ============================================================================
module mul_rr_pick
   import mul_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDXW = idxw(DEF_NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic            any,
   output logic [IDXW-1:0] idx
);

   logic [2*NREQ-1:0] w_dbl;
   logic [NREQ-1:0]   w_rot;
   logic [IDXW:0]     w_sum;

   assign w_dbl = {req, req} >> ptr;
   assign w_rot = w_dbl[NREQ-1:0];

   // Scan downward so the lowest rotated offset is the last (winning) write.
   always_comb begin
      any   = 1'b0;
      idx   = '0;
      w_sum = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            any   = 1'b1;
            w_sum = {1'b0, ptr} + (IDXW+1)'(k);
            if (w_sum >= (IDXW+1)'(NREQ)) begin
               w_sum = w_sum - (IDXW+1)'(NREQ);
            end
            idx = w_sum[IDXW-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// mul_share_arbiter : round-robin sharing of one req/ack multiplier, with watchdog
// Rev 1.0
// ============================================================================
module mul_share_arbiter
   import mul_arb_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] p0,
   input  logic [NREQ*WIDTH-1:0] p1,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      out,
   output logic                  err,
   output logic                  m_req,
   output logic [WIDTH-1:0]      m_p0,
   output logic [WIDTH-1:0]      m_p1,
   input  logic                  m_ack,
   input  logic [WIDTH-1:0]      m_out
);

   localparam int              IDXW      = idxw(NREQ);
   localparam logic [7:0]      c_TIMEOUT = 8'(TIMEOUT);
   localparam logic [IDXW-1:0] c_LAST    = IDXW'(NREQ - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [IDXW-1:0]  r_ptr;
   logic [IDXW-1:0]  r_gnt;
   logic [7:0]       r_timer;
   logic [NREQ-1:0]  r_ack;
   logic [WIDTH-1:0] r_out;
   logic             r_err;
   logic             r_m_req;
   logic [WIDTH-1:0] r_m_p0;
   logic [WIDTH-1:0] r_m_p1;

   logic             w_pick_any;
   logic [IDXW-1:0]  w_pick_idx;
   logic             w_grant;
   logic             w_done_ack;
   logic             w_done_to;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [NREQ-1:0]  w_gnt_onehot;
   logic [IDXW-1:0]  w_ptr_adv;

   mul_rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .req (req),
      .ptr (r_ptr),
      .any (w_pick_any),
      .idx (w_pick_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_pick_any) w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_done_ack || w_done_to) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A real m_ack takes precedence over the watchdog firing in the same cycle.
   always_comb begin
      w_grant      = 1'b0;
      w_done_ack   = 1'b0;
      w_done_to    = 1'b0;
      w_sel_a      = '0;
      w_sel_b      = '0;
      w_gnt_onehot = '0;
      case (r_state)
         S_IDLE:  w_grant = w_pick_any;
         S_ISSUE: begin
            w_done_ack = m_ack;
            w_done_to  = !m_ack && (r_timer == c_TIMEOUT);
         end
         default: ;
      endcase
      for (int k = 0; k < NREQ; k++) begin
         if (w_pick_idx == IDXW'(k)) begin
            w_sel_a = p0[k*WIDTH +: WIDTH];
            w_sel_b = p1[k*WIDTH +: WIDTH];
         end
         w_gnt_onehot[k] = (r_gnt == IDXW'(k));
      end
      w_ptr_adv = (r_gnt == c_LAST) ? '0 : r_gnt + IDXW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_timer <= '0;
         r_ack   <= '0;
         r_out   <= '0;
         r_err   <= 1'b0;
         r_m_req <= 1'b0;
         r_m_p0  <= '0;
         r_m_p1  <= '0;
      end else begin
         r_ack <= '0;
         r_err <= 1'b0;
         if (w_grant) begin
            r_gnt   <= w_pick_idx;
            r_m_p0  <= w_sel_a;
            r_m_p1  <= w_sel_b;
            r_m_req <= 1'b1;
            r_timer <= '0;
         end else if (w_done_ack || w_done_to) begin
            r_ack   <= w_gnt_onehot;
            r_err   <= w_done_to;
            r_out   <= w_done_ack ? m_out : '0;
            r_m_req <= 1'b0;
            r_ptr   <= w_ptr_adv;
         end else if (r_state == S_ISSUE) begin
            r_timer <= r_timer + 8'd1;
         end
      end
   end

   assign ack   = r_ack;
   assign out   = r_out;
   assign err   = r_err;
   assign m_req = r_m_req;
   assign m_p0  = r_m_p0;
   assign m_p1  = r_m_p1;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mul_share_arbiter : directed stimulus plus transaction-level reference model
// Rev 1.0
// ============================================================================
module tb_mul_share_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int TO    = 8;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] p0  = '0;
   logic [NREQ*WIDTH-1:0] p1  = '0;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      out;
   logic                  err;
   logic                  m_req;
   logic [WIDTH-1:0]      m_p0;
   logic [WIDTH-1:0]      m_p1;
   logic                  m_ack = 1'b0;
   logic [WIDTH-1:0]      m_out = '0;

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic auto_en  = 1'b1;
   int   lat      = 5;
   int   inj_at   = -1;
   int   mcnt     = 0;

   mul_share_arbiter #(
      .NREQ    (NREQ),
      .WIDTH   (WIDTH),
      .TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .p0    (p0),
      .p1    (p1),
      .ack   (ack),
      .out   (out),
      .err   (err),
      .m_req (m_req),
      .m_p0  (m_p0),
      .m_p1  (m_p1),
      .m_ack (m_ack),
      .m_out (m_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream multiplier: acks `lat` cycles after m_req rises, or on an injected cycle.
   always @(posedge clk) begin
      #2;
      if (m_req) mcnt = mcnt + 1;
      else       mcnt = 0;
      if (cyc == inj_at) begin
         m_ack = 1'b1;
         m_out = 32'hDEAD_BEEF;
      end else if (auto_en && m_req && mcnt == lat) begin
         m_ack = 1'b1;
         m_out = m_p0 * m_p1;
      end else begin
         m_ack = 1'b0;
         m_out = '0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] word(input logic [NREQ*WIDTH-1:0] v, input int i);
      logic [NREQ*WIDTH-1:0] t;
      t = v >> (i * WIDTH);
      return t[WIDTH-1:0];
   endfunction

   function automatic logic has(input logic [NREQ-1:0] v, input int j);
      logic [NREQ-1:0] t;
      t = v >> j;
      return t[0];
   endfunction

   task automatic compare_loop();
      logic [NREQ-1:0]       s_req     = '0;
      logic [NREQ*WIDTH-1:0] s_p0      = '0;
      logic [NREQ*WIDTH-1:0] s_p1      = '0;
      logic                  s_mack    = 1'b0;
      logic [WIDTH-1:0]      s_mout    = '0;
      logic                  prev_mreq = 1'b0;
      logic                  idle_next = 1'b1;
      logic                  pending   = 1'b0;
      logic                  done;
      logic                  exp_err;
      logic                  rose;
      logic [NREQ-1:0]       exp_ack;
      logic [WIDTH-1:0]      exp_a     = '0;
      logic [WIDTH-1:0]      exp_b     = '0;
      logic [WIDTH-1:0]      last_out  = '0;
      int                    ptr       = 0;
      int                    win       = 0;
      int                    k         = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            ptr       = 0;
            pending   = 1'b0;
            idle_next = 1'b1;
            last_out  = '0;
            check("rst_ack", ack, 0);
            check("rst_mreq", m_req, 0);
            check("rst_out", out, 0);
            check("rst_err", err, 0);
         end else begin
            exp_ack = '0;
            exp_err = 1'b0;
            done    = 1'b0;
            rose    = m_req && !prev_mreq;
            if (idle_next) begin
               check("grant_iff_req", rose, (s_req != 0));
               if (s_req != 0) begin
                  win = -1;
                  for (int o = 0; o < NREQ; o++) begin
                     if (win < 0 && has(s_req, (ptr + o) % NREQ)) win = (ptr + o) % NREQ;
                  end
                  exp_a   = word(s_p0, win);
                  exp_b   = word(s_p1, win);
                  pending = 1'b1;
                  k       = 0;
                  check("grant_m_p0", m_p0, exp_a);
                  check("grant_m_p1", m_p1, exp_b);
               end
            end else if (pending) begin
               k++;
               if (s_mack) begin
                  done     = 1'b1;
                  last_out = s_mout;
               end else if (k == TO + 1) begin
                  done     = 1'b1;
                  exp_err  = 1'b1;
                  last_out = '0;
               end
               if (done) begin
                  exp_ack = NREQ'(1) << win;
                  pending = 1'b0;
                  ptr     = (win + 1) % NREQ;
               end else begin
                  check("hold_m_p0", m_p0, exp_a);
                  check("hold_m_p1", m_p1, exp_b);
               end
            end else begin
               check("no_grant_in_done", rose, 0);
            end
            check("ack", ack, exp_ack);
            check("err", err, exp_err);
            check("out", out, last_out);
            check("m_req", m_req, pending);
            idle_next = !pending && !done;
         end
         s_req     = req;
         s_p0      = p0;
         s_p1      = p1;
         s_mack    = m_ack;
         s_mout    = m_out;
         prev_mreq = m_req;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [NREQ*WIDTH-1:0] m;
      m  = {{((NREQ-1)*WIDTH){1'b0}}, {WIDTH{1'b1}}} << (i * WIDTH);
      p0 = (p0 & ~m) | ({{((NREQ-1)*WIDTH){1'b0}}, a} << (i * WIDTH));
      p1 = (p1 & ~m) | ({{((NREQ-1)*WIDTH){1'b0}}, b} << (i * WIDTH));
   endtask

   task automatic wait_grant(output int t);
      logic got;
      got = 1'b0;
      t   = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         if (m_req) begin
            got = 1'b1;
            t   = cyc;
         end else begin
            tick(1);
         end
      end
      check("grant_seen", got, 1);
   endtask

   // Returns one clock after the ack cycle, before the next IDLE evaluation.
   task automatic wait_ack(output int idx, output logic e, output logic [WIDTH-1:0] o,
                           output int t, output logic mr);
      logic got;
      got = 1'b0;
      idx = -1;
      e   = 1'b0;
      o   = '0;
      t   = 0;
      mr  = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (ack != 0) begin
            got = 1'b1;
            for (int j = 0; j < NREQ; j++) if (has(ack, j)) idx = j;
            e  = err;
            o  = out;
            t  = cyc;
            mr = m_req;
         end
      end
      check("ack_seen", got, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic main_seq();
      int               g;
      int               t;
      int               idx;
      logic             e;
      logic             mr;
      logic [WIDTH-1:0] o;
      int               exp_order[5] = '{0, 1, 2, 3, 0};

      rst = 1'b1;
      #1 rst = 1'b0;
      tick(3);
      check("reset_m_req", m_req, 0);
      check("reset_m_p0", m_p0, 0);
      check("reset_out", out, 0);
      check("reset_ack", ack, 0);
      rst = 1'b1;
      tick(2);

      // Single request; operands change after grant and must not matter
      set_ops(0, 7, 6);
      req = 4'b0001;
      tick(1);
      check("single_m_req", m_req, 1);
      check("single_m_p0", m_p0, 7);
      check("single_m_p1", m_p1, 6);
      g = cyc;
      set_ops(0, 100, 100);
      wait_ack(idx, e, o, t, mr);
      check("single_idx", idx, 0);
      check("single_out", o, 42);
      check("single_err", e, 0);
      check("single_lat", t - g, 5);
      check("single_mreq_in_ack", mr, 0);
      req = 4'b0000;

      set_ops(3, 5, 9);
      req = 4'b1000;
      wait_ack(idx, e, o, t, mr);
      check("skip_idx", idx, 3);
      check("skip_out", o, 45);
      req = 4'b0000;

      // Round robin from pointer 0 with every requester re-raising
      for (int i = 0; i < NREQ; i++) set_ops(i, i + 2, 3 * i + 1);
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_ack(idx, e, o, t, mr);
         check("rr_order", idx, exp_order[n]);
         check("rr_out", o, (idx + 2) * (3 * idx + 1));
         if (idx >= 0) req = req & ~(NREQ'(1) << idx);
         tick(1);
         if (n < 4 && idx >= 0) req = req | (NREQ'(1) << idx);
      end
      req = 4'b0000;
      wait_ack(idx, e, o, t, mr);
      check("drop_while_granted_idx", idx, 1);
      check("drop_while_granted_out", o, 12);

      // Pointer wrap: bring pointer to 3, then req 0110 -> 1 then 2
      set_ops(2, 11, 13);
      req = 4'b0100;
      wait_ack(idx, e, o, t, mr);
      check("ptr3_setup_out", o, 143);
      req = 4'b0110;
      wait_ack(idx, e, o, t, mr);
      check("wrap_first", idx, 1);
      req = 4'b0100;
      wait_ack(idx, e, o, t, mr);
      check("wrap_second", idx, 2);
      set_ops(0, 2, 1);
      req = 4'b1001;
      wait_ack(idx, e, o, t, mr);
      check("wrap_ptr_end", idx, 3);

      // Timeout: requester 0 still requesting, multiplier silent
      req     = 4'b0001;
      auto_en = 1'b0;
      wait_grant(g);
      wait_ack(idx, e, o, t, mr);
      check("to_idx", idx, 0);
      check("to_err", e, 1);
      check("to_out", o, 0);
      check("to_lat", t - g, TO + 1);
      auto_en = 1'b1;
      req     = 4'b0010;
      wait_ack(idx, e, o, t, mr);
      check("after_to_idx", idx, 1);
      check("after_to_err", e, 0);
      check("after_to_out", o, 12);
      req = 4'b0000;

      // m_ack on the same cycle the watchdog expires
      lat = 9;
      req = 4'b0100;
      wait_grant(g);
      wait_ack(idx, e, o, t, mr);
      check("coll_idx", idx, 2);
      check("coll_err", e, 0);
      check("coll_out", o, 143);
      check("coll_lat", t - g, TO + 1);
      req = 4'b0000;
      lat = 5;

      // Stray m_ack in IDLE must not ack or move the pointer
      inj_at = cyc + 1;
      tick(4);
      check("idle_inj_out", out, 143);
      check("idle_inj_m_req", m_req, 0);
      req = 4'b1001;
      wait_ack(idx, e, o, t, mr);
      check("idle_inj_ptr", idx, 3);
      req = 4'b0000;

      // Asynchronous reset in the middle of ISSUE
      lat = 20;
      set_ops(0, 7, 6);
      req = 4'b0001;
      wait_grant(g);
      tick(2);
      #2;
      rst = 1'b0;
      #1;
      check("arst_m_req", m_req, 0);
      check("arst_ack", ack, 0);
      check("arst_m_p0", m_p0, 0);
      req = 4'b0000;
      tick(2);
      rst    = 1'b1;
      inj_at = cyc;
      tick(3);
      check("stale_out", out, 0);
      check("stale_m_req", m_req, 0);
      lat = 5;
      set_ops(2, 9, 9);
      req = 4'b0100;
      wait_ack(idx, e, o, t, mr);
      check("post_rst_idx", idx, 2);
      check("post_rst_out", o, 81);
      check("post_rst_err", e, 0);
      req = 4'b0000;
      tick(3);
   endtask

   initial begin
      fork
         compare_loop();
         main_seq();
      join_any
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one iterative multiplier (mul32x32_fsm-style req/ack unit behind hls_MulFSM) between NREQ independent requesters, such as HLS kernels and the CPU MMIO path. It runs round-robin arbitration, registers the winner's operands, and sequences the downstream req/ack handshake. It routes the result back with a one-cycle ack pulse to the winner only. A watchdog recovers from a downstream unit that never acks.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width
TIMEOUT, 255, max cycles waiting for m_ack before abort (8-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester level request; held until its ack pulse
p0  in  NREQ*WIDTH  flattened operand A; slice i = p0[i*WIDTH +: WIDTH]
p1  in  NREQ*WIDTH  flattened operand B, same slicing
ack  out  NREQ  one-hot one-cycle completion pulse
out  out  WIDTH  result; valid only in the ack cycle
err  out  1  high with the ack pulse when the transaction timed out
m_req  out  1  request to multiplier; level, held until m_ack
m_p0  out  WIDTH  registered operand A to multiplier
m_p1  out  WIDTH  registered operand B to multiplier
m_ack  in  1  multiplier done pulse; m_out valid same cycle
m_out  in  WIDTH  multiplier result

Behaviour:
- Reset (async, rst=0): state=IDLE, rr_ptr=0, ack=0, out=0, err=0, m_req=0, m_p0=0, m_p1=0, timer=0. Reset mid-transaction aborts silently: no ack is issued, and a late m_ack after reset release is ignored in IDLE.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: if any req bit is set, the winner is the first set bit scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - Same edge: latch gnt_idx, m_p0/m_p1 from the winner's slices, m_req<=1, timer<=0, go to ISSUE.
  - With no request, stay in IDLE; all outputs hold, ack=0.
- ISSUE: m_req held at 1, and the timer increments each cycle.
  - m_ack=1: out<=m_out, ack[gnt_idx]<=1, err<=0, m_req<=0, rr_ptr<=gnt_idx+1 mod NREQ, go to DONE.
  - Else if timer==TIMEOUT: out<=0, err<=1, ack[gnt_idx]<=1, m_req<=0, rr_ptr advances as above, go to DONE.
  - m_ack and timeout in the same cycle: m_ack wins, err=0.
- DONE: ack/err high for exactly this cycle, then cleared; go to IDLE.
  - The requester drops req on the cycle after ack. The extra IDLE evaluation cycle guarantees a dropped req is never re-granted.
- Latency: req high at edge N gives m_req=1 after N. m_ack at edge M gives ack=1 after M. Minimum back-to-back issue spacing is 3 cycles.
- Operands are sampled only at grant; later changes to p0/p1 have no effect.
- A req deasserted while granted is ignored: the transaction completes and the ack still pulses.
- An m_ack seen outside ISSUE is ignored.
- out holds its last value between acks.
- Fairness: a continuously requesting set of k requesters is served in strict rotation; each waits at most k-1 transactions.

Decomposition:
- Shared package mul_arb_pkg: state encodings (S_IDLE=2'd0, S_ISSUE=2'd1, S_DONE=2'd2), default NREQ/WIDTH/TIMEOUT, and the IDXW = clog2(NREQ) function.
- One sub-module, mul_rr_pick: combinational rotate-priority encoder. Inputs are req[NREQ] and ptr[IDXW]; outputs are any and idx[IDXW].

Test Plan:
- Single request: req=4'b0001, p0=7, p1=6, model acks after 5 cycles with m_out=42 -> m_p0=7/m_p1=6 one cycle after req; ack=4'b0001 for one cycle with out=42, err=0; m_req low in the ack cycle.
- Round-robin: req=4'b1111 held, each requester re-raising req after its ack -> grant order 0,1,2,3,0; ack never repeats a requester while others wait.
- Pointer wrap and skip: rr_ptr=3, req=4'b0110 -> requester 1 granted, then requester 2; rr_ptr ends at 3.
- Timeout: model never acks, TIMEOUT=8 -> ack to the winner exactly TIMEOUT+1 cycles after m_req rises, with out=0, err=1; next grant proceeds normally.
- Collision: m_ack on the same cycle as timer==TIMEOUT -> err=0, out=m_out. An m_ack injected in IDLE -> no ack, no state change.
- Async reset mid-ISSUE: pull rst low with no clk edge -> m_req=0, ack=0 immediately. After release, a stale m_ack is ignored and a fresh req=4'b0100 is granted to requester 2.
